// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, default frame constants and parity helper.
// Build macro UART_TX_PARITY_EN adds the PARITY state to the transmit FSM.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_WIDTH   = 8;
  localparam int UART_STOP_BITS    = 1;
  localparam int UART_PARITY_MAX_W = 32;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_tx_state_t;
`endif

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared by transmit and receive paths.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, data LSB-first, optional even parity, stop bits.
// Build macro UART_TX_PARITY_EN inserts the even parity bit after the data bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int STOP_BITS    = UART_STOP_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_t        state, state_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
  logic                  stop_idx, stop_idx_nxt;
  logic                  tx_q, tx_nxt;
  logic                  done_c;
  logic                  tick;
  logic                  hs;

  assign data_ready = (state == ST_IDLE) && !rst;
  assign hs         = data_valid && data_ready;
  assign busy       = (state != ST_IDLE);
  assign done       = done_c && !rst;
  assign tx         = tx_q;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ST_IDLE),
    .tick  (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (hs) par_bit <= even_parity(UART_PARITY_MAX_W'(data_in));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      tx_q     <= tx_nxt;
    end
    shift <= shift_nxt;
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    done_c       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          state_nxt    = ST_START;
          shift_nxt    = data_in;
          bit_idx_nxt  = '0;
          stop_idx_nxt = 1'b0;
        end
      end
      ST_START: if (tick) state_nxt = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            shift_nxt   = shift >> 1;
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (tick) state_nxt = ST_STOP;
`endif
      ST_STOP: begin
        if (tick) begin
          if (stop_idx == LAST_STOP) begin
            state_nxt = ST_IDLE;
            done_c    = 1'b1;
          end else begin
            stop_idx_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // tx is registered, so it is decoded from the state being entered
    tx_nxt = 1'b1;
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_nxt = par_bit;
`endif
      default:   tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: two instances (1 and 2 stop bits) driven with
// directed and random bytes; a per-lane monitor checks every cycle against the expected frame.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int ABORT_LEN = 4 * CPB;

  typedef struct {
    logic [7:0] data;
    int         start_n;
    int         len;
    bit         abort;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 0;
  bit   go_a = 0;
  bit   go_b = 0;
  int   b_edge = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Serial level of frame bit idx: start, data LSB first, optional even parity, stop
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return b[idx-1];
    if (PB == 1 && idx == DW + 1) return ^b;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int SB = g + 1;
    localparam int FL = (1 + DW + PB + SB) * CPB;

    logic [7:0] din;
    logic       dv;
    logic       rdy, txl, bsy, dn;
    frame_t     exp_q[$];
    int         free_n;
    bit         drv_a, drv_c;
    bit         in_frame;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (din),
      .data_valid (dv),
      .data_ready (rdy),
      .tx         (txl),
      .busy       (bsy),
      .done       (dn)
    );

    // mode 0: quiet while busy, 1: random valid pulses while busy, 2: hold valid with b
    task automatic send(input logic [7:0] b, input int gap, input int mode);
      int n = 0;
      forever begin
        @(negedge clk);
        if (cyc >= free_n && n >= gap) break;
        if (cyc < free_n && mode == 1) begin
          dv  = 1'($urandom_range(0, 1));
          din = 8'($urandom);
        end else if (cyc < free_n && mode == 2) begin
          dv  = 1'b1;
          din = b;
        end else begin
          dv = 1'b0;
        end
        if (cyc >= free_n) n++;
      end
      dv  = 1'b1;
      din = b;
      exp_q.push_back('{data: b, start_n: cyc + 1, len: FL, abort: 1'b0});
      free_n = cyc + 1 + FL;
      @(posedge clk);
    endtask

    initial begin
      dv = 1'b0;
      din = '0;
      free_n = 0;
      drv_a = 0;
      drv_c = 0;
      wait (go_a);
      send(8'hA5, 2, 0);
      send(8'h01, 3, 1);
      send(8'h55, 1, 0);
      send(8'h0F, 0, 2);
      for (int i = 0; i < 10; i++)
        send(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      @(negedge clk) dv = 1'b0;
      drv_a = 1;

      wait (go_b);
      do @(negedge clk); while (cyc < b_edge - 1);
      dv  = 1'b1;
      din = 8'($urandom);
      exp_q.push_back('{data: din, start_n: b_edge, len: ABORT_LEN, abort: 1'b1});
      free_n = b_edge + 18;
      @(negedge clk) dv = 1'b0;
      send(8'hC3, 0, 0);
      for (int i = 0; i < 6; i++)
        send(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      @(negedge clk) dv = 1'b0;
      drv_c = 1;
    end

    initial begin
      frame_t cur;
      int k = 0;
      in_frame = 0;
      wait (mon_en);
      forever begin
        @(posedge clk);
        #1;
        if (!in_frame) begin
          if (bsy === 1'b1) begin
            if (exp_q.size() == 0) begin
              check($sformatf("L%0d unexpected frame", g), 32'd1, 32'd0);
            end else begin
              cur = exp_q.pop_front();
              check($sformatf("L%0d frame start cycle", g), cyc, cur.start_n);
              in_frame = 1;
              k = 0;
            end
          end else begin
            check($sformatf("L%0d idle tx", g), txl, 1'b1);
            check($sformatf("L%0d idle done", g), dn, 1'b0);
            check($sformatf("L%0d idle busy", g), bsy, 1'b0);
            check($sformatf("L%0d idle ready", g), rdy, !rst);
          end
        end
        if (in_frame) begin
          check($sformatf("L%0d tx bit%0d of %0h", g, k / CPB, cur.data), txl,
                exp_bit(cur.data, k / CPB));
          check($sformatf("L%0d busy", g), bsy, 1'b1);
          check($sformatf("L%0d ready in frame", g), rdy, 1'b0);
          check($sformatf("L%0d done k=%0d", g, k), dn, (k == cur.len - 1) && !cur.abort);
          k++;
          if (k == cur.len) in_frame = 0;
        end
      end
    end
  end

  initial begin
    int t;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("L0 reset tx", lane[0].txl, 1'b1);
      check("L0 reset busy", lane[0].bsy, 1'b0);
      check("L0 reset done", lane[0].dn, 1'b0);
      check("L0 reset ready", lane[0].rdy, 1'b0);
      check("L1 reset tx", lane[1].txl, 1'b1);
      check("L1 reset ready", lane[1].rdy, 1'b0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("L0 ready after reset", lane[0].rdy, 1'b1);
    check("L1 ready after reset", lane[1].rdy, 1'b1);
    mon_en = 1;
    go_a = 1;

    for (t = 0; t < 20000 && !(lane[0].drv_a && lane[1].drv_a); t++) @(posedge clk);
    check("phase A finished in budget", 32'(lane[0].drv_a && lane[1].drv_a), 32'd1);
    for (t = 0; t < 200 && (cyc < lane[0].free_n + 2 || cyc < lane[1].free_n + 2); t++)
      @(posedge clk);
    #1;
    b_edge = cyc + 4;
    go_b = 1;
    do @(negedge clk); while (cyc < b_edge + ABORT_LEN - 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    for (t = 0; t < 20000 && !(lane[0].drv_c && lane[1].drv_c); t++) @(posedge clk);
    check("phase C finished in budget", 32'(lane[0].drv_c && lane[1].drv_c), 32'd1);
    for (t = 0; t < 200 && (cyc < lane[0].free_n + 3 || cyc < lane[1].free_n + 3); t++)
      @(posedge clk);
    #1;
    check("L0 frames pending", lane[0].exp_q.size(), 0);
    check("L1 frames pending", lane[1].exp_q.size(), 0);
    check("L0 frame open", 32'(lane[0].in_frame), 32'd0);
    check("L1 frame open", 32'(lane[1].in_frame), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
